// File: rtl/fifo_burst_drain.sv
// Read-side burst controller for a 16x16 synchronous FIFO: issues read bursts,
// captures the registered FIFO output and delivers it on a valid/ready stream via a 2-entry skid buffer.
module fifo_burst_drain #(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic             fifo_half,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read,
  input  logic             flush,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             burst_done,
  output logic [15:0]      words_read
);

  typedef enum logic [1:0] {IDLE, BURST, WAIT} state_t;

  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  state_t           state_reg, state_next;
  logic [3:0]       bcnt_reg, bcnt_next;
  logic             inflight_reg;
  logic [1:0]       occ_reg, occ_next;
  logic [WIDTH-1:0] skid_reg  [2];
  logic [WIDTH-1:0] skid_next [2];
  logic [15:0]      words_read_reg;

  logic       pop;
  logic       push;
  logic [1:0] credit_sum;
  logic       credit_ok;
  logic [1:0] wr_idx;

  assign pop  = (occ_reg != 2'd0) & dout_ready;
  assign push = inflight_reg;

  // Occupancy is taken after this cycle's transfer so that a word leaving
  // frees its slot immediately; this sustains one read per cycle while ready.
  assign credit_sum = (occ_reg - {1'b0, pop}) + {1'b0, inflight_reg};
  assign credit_ok  = (credit_sum < 2'd2);

  always_comb begin
    state_next = state_reg;
    bcnt_next  = bcnt_reg;
    fifo_read  = 1'b0;
    burst_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((fifo_half | flush) & !fifo_empty) begin
          state_next = BURST;
          bcnt_next  = 4'd0;
        end
      end
      BURST: begin
        fifo_read = !fifo_empty & (bcnt_reg < BURST_MAX) & credit_ok;
        if (fifo_read)
          bcnt_next = bcnt_reg + 4'd1;
        if ((bcnt_reg == BURST_MAX) || (fifo_empty && !fifo_read))
          state_next = WAIT;
      end
      WAIT: begin
        if (!inflight_reg) begin
          burst_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      fifo_read  = 1'b0;
      burst_done = 1'b0;
    end
  end

  // Skid buffer: entry 0 is the head; a captured word lands behind any
  // word that stays, so FIFO order is preserved on simultaneous push/pop.
  always_comb begin
    skid_next[0] = skid_reg[0];
    skid_next[1] = skid_reg[1];
    wr_idx       = occ_reg - {1'b0, pop};
    if (pop)
      skid_next[0] = skid_reg[1];
    if (push)
      skid_next[wr_idx[0]] = fifo_data;
    occ_next = occ_reg + {1'b0, push} - {1'b0, pop};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_skid
      always_ff @(posedge clock) begin
        if (reset)
          skid_reg[gi] <= '0;
        else
          skid_reg[gi] <= skid_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      bcnt_reg       <= 4'd0;
      inflight_reg   <= 1'b0;
      occ_reg        <= 2'd0;
      words_read_reg <= 16'd0;
    end else begin
      state_reg      <= state_next;
      bcnt_reg       <= bcnt_next;
      inflight_reg   <= fifo_read;
      occ_reg        <= occ_next;
      words_read_reg <= words_read_reg + {15'd0, pop};
    end
  end

  assign dout       = skid_reg[0];
  assign dout_valid = (occ_reg != 2'd0);
  assign busy       = (state_reg != IDLE);
  assign words_read = words_read_reg;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: a queue-based FIFO model feeds the DUT, and a scoreboard
// checks stream order, hold, credit and counters every cycle, plus directed literal checks.
module tb_fifo_burst_drain;
  localparam int WIDTH = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             fifo_empty = 1'b1;
  logic             fifo_half = 1'b0;
  logic [WIDTH-1:0] fifo_data = '0;
  logic             flush = 1'b0;
  logic             dout_ready = 1'b0;
  logic             fifo_read;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             burst_done;
  logic [15:0]      words_read;

  fifo_burst_drain #(.WIDTH(WIDTH), .BURST_LEN(8)) dut (
    .clock(clock), .reset(reset),
    .fifo_empty(fifo_empty), .fifo_half(fifo_half), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .flush(flush),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .burst_done(burst_done), .words_read(words_read)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [15:0] fq[$];
  logic [15:0] exp_q[$];
  logic [15:0] log_q[$];
  int          burst_q[$];
  int          read_cyc[$];
  int          xfer_cyc[$];
  int          cyc = 0;
  logic [15:0] model_wr = 16'd0;
  int          reads_tot = 0;
  int          deliv_tot = 0;
  int          burst_reads = 0;
  int          busy_cycles = 0;
  logic        hold_prev = 1'b0;
  logic [15:0] prev_dout = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void update_flags();
    fifo_empty = (fq.size() == 0);
    fifo_half  = (fq.size() == 8);
  endfunction

  task automatic push_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 16'(i));
    update_flags();
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    log_q.delete();
    burst_q.delete();
    read_cyc.delete();
    xfer_cyc.delete();
    busy_cycles = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    dout_ready = 1'b0;
    fq.delete();
    update_flags();
    run(2);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic check_seq(input string name, input logic [15:0] base, input int n);
    check({name, "_len"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++)
      check(name, log_q[i], base + 16'(i));
  endtask

  // FIFO model: registered output updates one edge after the read strobe.
  initial begin
    forever begin
      logic rd;
      @(posedge clock);
      rd = fifo_read;
      #1;
      if (rd) begin
        check("no_underflow", fq.size() != 0, 1);
        if (fq.size() != 0) begin
          fifo_data = fq.pop_front();
          exp_q.push_back(fifo_data);
        end
        update_flags();
      end
    end
  end

  // Per-cycle scoreboard and invariants.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      model_wr    = 16'd0;
      reads_tot   = 0;
      deliv_tot   = 0;
      burst_reads = 0;
      hold_prev   = 1'b0;
    end else begin
      check("words_read", words_read, model_wr);
      if (hold_prev) begin
        check("hold_valid", dout_valid, 1);
        check("hold_data", dout, prev_dout);
      end
      if (fifo_read) begin
        check("read_only_in_burst", busy, 1);
        reads_tot++;
        burst_reads++;
        read_cyc.push_back(cyc);
      end
      if (dout_valid && dout_ready) begin
        check("xfer_has_word", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("dout_order", dout, exp_q.pop_front());
        log_q.push_back(dout);
        xfer_cyc.push_back(cyc);
        deliv_tot++;
        model_wr = model_wr + 16'd1;
        $display("xfer #%0d cycle %0d dout=0x%04h", deliv_tot, cyc, dout);
      end
      check("credit_le2", (reads_tot - deliv_tot) <= 2, 1);
      if (burst_done) begin
        burst_q.push_back(burst_reads);
        burst_reads = 0;
      end
      if (busy) busy_cycles++;
      hold_prev = dout_valid && !dout_ready;
      prev_dout = dout;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pushed;
    #2;
    // 1: reset, empty FIFO
    do_reset();
    run(4);
    check("t1_fifo_read", fifo_read, 0);
    check("t1_dout_valid", dout_valid, 0);
    check("t1_busy", busy, 0);
    check("t1_words_read", words_read, 0);
    check("t1_dout", dout, 0);

    // 2: 8 words, ready high: back-to-back reads, gapless stream
    do_reset();
    dout_ready = 1'b1;
    push_words(16'h0001, 8);
    run(20);
    check_seq("t2_seq", 16'h0001, 8);
    check("t2_bursts", burst_q.size(), 1);
    if (burst_q.size() >= 1) check("t2_burst_len", burst_q[0], 8);
    check("t2_words_read", words_read, 8);
    check("t2_reads", read_cyc.size(), 8);
    if (read_cyc.size() == 8 && xfer_cyc.size() == 8) begin
      check("t2_read_span", read_cyc[7] - read_cyc[0], 7);
      check("t2_xfer_span", xfer_cyc[7] - xfer_cyc[0], 7);
      check("t2_latency", xfer_cyc[0] - read_cyc[0], 2);
    end
    check("t2_busy_end", busy, 0);

    // 3: consumer stalled: only 2 reads, then everything drains in order
    do_reset();
    push_words(16'h0011, 8);
    run(10);
    check("t3_reads_stalled", read_cyc.size(), 2);
    check("t3_fifo_read", fifo_read, 0);
    check("t3_dout_valid", dout_valid, 1);
    check("t3_dout_head", dout, 16'h0011);
    dout_ready = 1'b1;
    run(20);
    check_seq("t3_seq", 16'h0011, 8);
    check("t3_words_read", words_read, 8);
    check("t3_bursts", burst_q.size(), 1);

    // 4: below half, no flush: idle; flush pulse drains 3
    do_reset();
    dout_ready = 1'b1;
    push_words(16'h0021, 3);
    run(6);
    check("t4_idle_busy", busy_cycles, 0);
    check("t4_idle_reads", read_cyc.size(), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    run(15);
    check_seq("t4_seq", 16'h0021, 3);
    check("t4_bursts", burst_q.size(), 1);
    if (burst_q.size() >= 1) check("t4_burst_len", burst_q[0], 3);
    check("t4_words_read", words_read, 3);
    check("t4_busy_end", busy, 0);

    // 5: 15 words: burst of 8 on half, then 7 on flush
    do_reset();
    dout_ready = 1'b1;
    push_words(16'h0031, 8);
    tick();
    push_words(16'h0039, 7);
    run(20);
    check("t5_bursts_a", burst_q.size(), 1);
    if (burst_q.size() >= 1) check("t5_burst1_len", burst_q[0], 8);
    check("t5_busy_between", busy, 0);
    check("t5_words_read_a", words_read, 8);
    check("t5_fifo_left", fq.size(), 7);
    flush = 1'b1;
    run(20);
    flush = 1'b0;
    check("t5_bursts_b", burst_q.size(), 2);
    if (burst_q.size() >= 2) check("t5_burst2_len", burst_q[1], 7);
    check_seq("t5_seq", 16'h0031, 15);
    check("t5_words_read_b", words_read, 15);

    // 6: reset with 2 words buffered, then random-ready soak of 200 words
    do_reset();
    push_words(16'h0041, 8);
    run(6);
    check("t6_buffered_valid", dout_valid, 1);
    check("t6_buffered_reads", read_cyc.size(), 2);
    reset = 1'b1;
    fq.delete();
    update_flags();
    tick();
    check("t6_rst_valid", dout_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_words", words_read, 0);
    check("t6_rst_read", fifo_read, 0);
    reset = 1'b0;
    clear_logs();
    flush = 1'b1;
    pushed = 0;
    for (int c = 0; c < 5000 && deliv_tot < 200; c++) begin
      if (pushed < 200 && fq.size() < 16) begin
        fq.push_back(16'h1000 + 16'(pushed));
        pushed++;
        update_flags();
      end
      dout_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check("t6_budget", deliv_tot >= 200, 1);
    dout_ready = 1'b1;
    run(10);
    flush = 1'b0;
    check_seq("t6_seq", 16'h1000, 200);
    check("t6_words_read", words_read, 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
